// File: rtl/tug_of_war_ctrl_if.sv
// Tug-of-war controller bus: player keys, playfield end lights and the
// game outputs bundled together. "master" is the environment side that
// supplies keys and end lights; "slave" is the controller.
interface tug_of_war_ctrl_if;
  logic       key_l;
  logic       key_r;
  logic       end_l_on;
  logic       end_r_on;
  logic [2:0] cpu_level;
  logic       L;
  logic       R;
  logic       field_reset;
  logic [2:0] score_l;
  logic [2:0] score_r;
  logic       win_l;
  logic       win_r;
  logic       game_over;

  modport master (
    output key_l, key_r, end_l_on, end_r_on, cpu_level,
    input  L, R, field_reset, score_l, score_r, win_l, win_r, game_over
  );

  modport slave (
    input  key_l, key_r, end_l_on, end_r_on, cpu_level,
    output L, R, field_reset, score_l, score_r, win_l, win_r, game_over
  );
endinterface

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game sequencer.
// Turns key levels into one-cycle presses, forwards them to the playfield
// while a round is live, scores round wins from the end lights, recenters
// the field between rounds and declares the match winner.
// Optional build macro CPU_PLAYER_EN: the right player becomes an LFSR-driven
// computer whose press rate is set by cpu_level; key_r is then ignored.
module tug_of_war_ctrl #(
  parameter int MAX_SCORE     = 7,
  parameter int FIELD_RST_CYC = 2,
  parameter int HOLD_CYC      = 4
) (
  input  logic              clk,
  input  logic              reset,
  tug_of_war_ctrl_if.slave  bus
);

  localparam int CNT_MAX = (FIELD_RST_CYC > HOLD_CYC) ? FIELD_RST_CYC : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FIELD_LAST = CNT_W'(FIELD_RST_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       SCORE_MAX  = 3'(MAX_SCORE);

  typedef enum logic [1:0] {
    FIELD_RST,
    PLAY,
    WIN,
    OVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       score_l_q, score_l_d;
  logic [2:0]       score_r_q, score_r_d;
  logic             win_l_q, win_l_d;
  logic             win_r_q, win_r_d;
  logic             game_over_q, game_over_d;
  logic             field_reset_q, field_reset_d;
  logic             key_l_q, key_l_d;

  logic             press_l;
  logic             press_r;
  logic             live;
  logic             round_win_l;
  logic             round_win_r;
  logic [2:0]       score_l_inc;
  logic [2:0]       score_r_inc;

`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr_q, lfsr_d;
  logic       cpu_q, cpu_d;
  logic       cpu_raw;
  logic       unused_key_r;

  assign unused_key_r = bus.key_r;

  // Computer player: free-running LFSR compared against the aggressiveness threshold
  always_comb begin
    cpu_raw = (lfsr_q < {bus.cpu_level, 7'b0});
    cpu_d   = cpu_raw;
    lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    press_r = cpu_raw & ~cpu_q;
  end

  // LFSR and previous-compare registers, seeded so the sequence never locks up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 10'h001;
      cpu_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      cpu_q  <= cpu_d;
    end
  end
`else
  logic       key_r_q, key_r_d;
  logic [2:0] unused_cpu_level;

  assign unused_cpu_level = bus.cpu_level;

  // Right press is the rising edge of the right key level
  always_comb begin
    key_r_d = bus.key_r;
    press_r = bus.key_r & ~key_r_q;
  end

  // Right key history; resets high so a key held through reset gives no press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r_q <= 1'b1;
    end else begin
      key_r_q <= key_r_d;
    end
  end
`endif

  // Left press detect plus round-win qualification and saturating increments
  always_comb begin
    key_l_d     = bus.key_l;
    press_l     = bus.key_l & ~key_l_q;
    live        = (state_q == PLAY);
    round_win_l = live & bus.end_l_on & ~bus.end_r_on & press_l & ~press_r;
    round_win_r = live & bus.end_r_on & ~bus.end_l_on & press_r & ~press_l;
    score_l_inc = (score_l_q >= SCORE_MAX) ? SCORE_MAX : score_l_q + 3'd1;
    score_r_inc = (score_r_q >= SCORE_MAX) ? SCORE_MAX : score_r_q + 3'd1;
  end

  // Next-state and registered-output logic for the round sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    win_l_d       = win_l_q;
    win_r_d       = win_r_q;
    game_over_d   = game_over_q;
    field_reset_d = field_reset_q;
    unique case (state_q)
      FIELD_RST: begin
        if (cnt_q == FIELD_LAST) begin
          state_d       = PLAY;
          cnt_d         = '0;
          field_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PLAY: begin
        if (round_win_l) begin
          score_l_d = score_l_inc;
          win_l_d   = 1'b1;
          cnt_d     = '0;
          if (score_l_inc == SCORE_MAX) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = WIN;
          end
        end else if (round_win_r) begin
          score_r_d = score_r_inc;
          win_r_d   = 1'b1;
          cnt_d     = '0;
          if (score_r_inc == SCORE_MAX) begin
            state_d     = OVER;
            game_over_d = 1'b1;
          end else begin
            state_d = WIN;
          end
        end
      end
      WIN: begin
        if (cnt_q == HOLD_LAST) begin
          state_d       = FIELD_RST;
          cnt_d         = '0;
          field_reset_d = 1'b1;
          win_l_d       = 1'b0;
          win_r_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d       = FIELD_RST;
        cnt_d         = '0;
        field_reset_d = 1'b1;
      end
    endcase
  end

  // Sequencer state, scores, flags and left key history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FIELD_RST;
      cnt_q         <= '0;
      score_l_q     <= 3'd0;
      score_r_q     <= 3'd0;
      win_l_q       <= 1'b0;
      win_r_q       <= 1'b0;
      game_over_q   <= 1'b0;
      field_reset_q <= 1'b1;
      key_l_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      win_l_q       <= win_l_d;
      win_r_q       <= win_r_d;
      game_over_q   <= game_over_d;
      field_reset_q <= field_reset_d;
      key_l_q       <= key_l_d;
    end
  end

  assign bus.L           = live & press_l;
  assign bus.R           = live & press_r;
  assign bus.field_reset = field_reset_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.win_l       = win_l_q;
  assign bus.win_r       = win_r_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Testbench for tug_of_war_ctrl: scenario tasks with randomized stimulus,
// checked against a countdown-based behavioural model of the game rules.
module tb_tug_of_war_ctrl;

  localparam int MAX_SCORE     = 7;
  localparam int FIELD_RST_CYC = 2;
  localparam int HOLD_CYC      = 4;

  logic clk = 1'b0;
  logic reset;

  tug_of_war_ctrl_if bus();

  tug_of_war_ctrl #(
    .MAX_SCORE    (MAX_SCORE),
    .FIELD_RST_CYC(FIELD_RST_CYC),
    .HOLD_CYC     (HOLD_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: cycles of recentering left, cycles of winner display
  // left, match-over flag, scores, round flags, key history and CPU player.
  int m_recenter;
  int m_hold;
  bit m_over;
  int m_sl;
  int m_sr;
  bit m_wl;
  bit m_wr;
  bit m_prev_l;
  bit m_prev_r;
  int m_lfsr;
  bit m_cpu_q;

  function automatic void model_reset();
    m_recenter = FIELD_RST_CYC;
    m_hold     = 0;
    m_over     = 1'b0;
    m_sl       = 0;
    m_sr       = 0;
    m_wl       = 1'b0;
    m_wr       = 1'b0;
    m_prev_l   = 1'b1;
    m_prev_r   = 1'b1;
    m_lfsr     = 1;
    m_cpu_q    = 1'b0;
  endfunction

  function automatic bit model_live();
    return (m_recenter == 0) && (m_hold == 0) && !m_over;
  endfunction

  function automatic bit model_press_r();
`ifdef CPU_PLAYER_EN
    return (m_lfsr < int'(bus.cpu_level) * 128) && !m_cpu_q;
`else
    return bus.key_r && !m_prev_r;
`endif
  endfunction

  function automatic logic [11:0] model_expected();
    bit live, pl, pr;
    live = model_live();
    pl   = bus.key_l && !m_prev_l;
    pr   = model_press_r();
    return {live && pl, live && pr, m_recenter > 0, 3'(m_sl), 3'(m_sr), m_wl, m_wr, m_over};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.L, bus.R, bus.field_reset, bus.score_l, bus.score_r,
            bus.win_l, bus.win_r, bus.game_over};
  endfunction

  task automatic drive(input bit kl, input bit kr, input bit el, input bit er);
    bus.key_l    = kl;
    bus.key_r    = kr;
    bus.end_l_on = el;
    bus.end_r_on = er;
  endtask

  // Advance one clock edge and apply the game rules to the model
  task automatic step();
    bit pl, pr;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      pl = bus.key_l && !m_prev_l;
      pr = model_press_r();
      if (m_recenter > 0) begin
        m_recenter--;
      end else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) begin
          m_recenter = FIELD_RST_CYC;
          m_wl = 1'b0;
          m_wr = 1'b0;
        end
      end else if (!m_over && !(bus.end_l_on && bus.end_r_on)) begin
        if (bus.end_l_on && pl && !pr) begin
          m_sl = (m_sl < MAX_SCORE) ? m_sl + 1 : MAX_SCORE;
          m_wl = 1'b1;
          if (m_sl == MAX_SCORE) m_over = 1'b1;
          else m_hold = HOLD_CYC;
        end else if (bus.end_r_on && pr && !pl) begin
          m_sr = (m_sr < MAX_SCORE) ? m_sr + 1 : MAX_SCORE;
          m_wr = 1'b1;
          if (m_sr == MAX_SCORE) m_over = 1'b1;
          else m_hold = HOLD_CYC;
        end
      end
      m_prev_l = bus.key_l;
      m_prev_r = bus.key_r;
      m_cpu_q  = (m_lfsr < int'(bus.cpu_level) * 128);
      m_lfsr   = ((m_lfsr * 2) % 1024) + (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    bus.cpu_level = 3'd0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({bus.L, bus.R, bus.field_reset, bus.score_l, bus.score_r, bus.game_over} !== 10'b0_0_1_000_000_0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold: got %b expected %b",
                 {bus.L, bus.R, bus.field_reset, bus.score_l, bus.score_r, bus.game_over}, 10'b0_0_1_000_000_0);
      end
      step();
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL reset_release_model cycle %0d: got %b expected %b", i, observed(), exp);
      end
      n_cmp++;
      if (bus.field_reset !== (i < 2)) begin
        n_fail++;
        $display("[TB] FAIL reset_field_reset cycle %0d: got %b expected %b", i, bus.field_reset, (i < 2));
      end
      step();
    end
  endtask

  task automatic test_press_pulse();
    logic [11:0] exp;
    bit seq [11] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int first_pulses = 0;
    int second_pulses = 0;
    for (int i = 0; i < 11; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b0);
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL press_pulse cycle %0d: got %b expected %b", i, observed(), exp);
      end
      if (bus.L === 1'b1) begin
        if (i < 5) first_pulses++;
        else second_pulses++;
      end
      step();
    end
    n_cmp++;
    if (first_pulses != 1 || second_pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL press_pulse_count: got %0d/%0d expected 1/1", first_pulses, second_pulses);
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    exp = model_expected();
    n_cmp++;
    if ({bus.L, bus.R} !== 2'b11 || observed() !== exp) begin
      n_fail++;
      $display("[TB] FAIL simultaneous_press: got %b expected %b", observed(), exp);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({bus.score_l, bus.win_l, bus.field_reset} !== 5'b000_0_0) begin
        n_fail++;
        $display("[TB] FAIL simultaneous_no_win: got %b expected %b",
                 {bus.score_l, bus.win_l, bus.field_reset}, 5'b000_0_0);
      end
      step();
    end
  endtask

  task automatic test_right_win();
    logic [11:0] exp;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    exp = model_expected();
    n_cmp++;
    if (bus.R !== 1'b1 || observed() !== exp) begin
      n_fail++;
      $display("[TB] FAIL right_press: got %b expected %b", observed(), exp);
    end
    step();
    for (int j = 0; j < 12; j++) begin
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, 1'b0);
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL right_win_model cycle %0d: got %b expected %b", j, observed(), exp);
      end
      n_cmp++;
      if ({bus.score_r, bus.win_r, bus.field_reset} !== {3'd1, (j < 4), (j == 4 || j == 5)}) begin
        n_fail++;
        $display("[TB] FAIL right_win_sequence cycle %0d: got %b expected %b", j,
                 {bus.score_r, bus.win_r, bus.field_reset}, {3'd1, (j < 4), (j == 4 || j == 5)});
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    int sel;
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            (sel == 6 || sel == 7 || sel == 9), (sel == 8 || sel == 9));
      bus.cpu_level = 3'($urandom_range(0, 7));
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL random cycle %0d: got %b expected %b", i, observed(), exp);
      end
      step();
    end
    bus.cpu_level = 3'd0;
  endtask

  task automatic test_match();
    logic [11:0] exp;
    int budget = 0;
    reset = 1'b1;
    bus.cpu_level = 3'd0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    model_reset();
    step();
    step();
    reset = 1'b0;
    while (!m_over && budget < 400) begin
      if (model_live() && !m_prev_l) drive(1'b1, 1'b0, 1'b1, 1'b0);
      else if (model_live()) drive(1'b0, 1'b0, 1'b0, 1'b0);
      else drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0, 1'b0);
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL match_model cycle %0d: got %b expected %b", budget, observed(), exp);
      end
      step();
      budget++;
    end
    n_cmp++;
    if (budget >= 400) begin
      n_fail++;
      $display("[TB] FAIL match_timeout: got %0d cycles expected fewer than 400", budget);
    end
    for (int i = 0; i < 10; i++) begin
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      #1;
      n_cmp++;
      if ({bus.L, bus.R, bus.field_reset, bus.score_l, bus.score_r, bus.win_l, bus.win_r, bus.game_over}
          !== {1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL match_over_hold cycle %0d: got %b expected %b", i, observed(),
                 {1'b0, 1'b0, 1'b0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b1});
      end
      step();
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({bus.field_reset, bus.score_l, bus.score_r, bus.win_l, bus.win_r, bus.game_over}
        !== {1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL match_reset_clear: got %b expected %b",
               {bus.field_reset, bus.score_l, bus.score_r, bus.win_l, bus.win_r, bus.game_over},
               {1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    end
    step();
    reset = 1'b0;
  endtask

`ifdef CPU_PLAYER_EN
  task automatic test_cpu();
    logic [11:0] exp;
    int r_pulses = 0;
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    bus.cpu_level = 3'd7;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      exp = model_expected();
      n_cmp++;
      if (observed() !== exp) begin
        n_fail++;
        $display("[TB] FAIL cpu_level7 cycle %0d: got %b expected %b", i, observed(), exp);
      end
      step();
    end
    n_cmp++;
    if (bus.score_r === 3'd0) begin
      n_fail++;
      $display("[TB] FAIL cpu_right_win: got score_r %0d expected nonzero", bus.score_r);
    end
    reset = 1'b1;
    model_reset();
    step();
    reset = 1'b0;
    bus.cpu_level = 3'd0;
    for (int i = 0; i < 2000; i++) begin
      drive(1'b0, bit'($urandom_range(0, 1)), 1'b0, 1'b1);
      #1;
      if (bus.R === 1'b1) r_pulses++;
      step();
    end
    n_cmp++;
    if (r_pulses != 0 || bus.score_r !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL cpu_level0: got %0d pulses score_r %0d expected 0 and 0", r_pulses, bus.score_r);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_press_pulse();
`ifndef CPU_PLAYER_EN
    test_simultaneous();
    test_right_win();
`else
    test_cpu();
`endif
    test_random();
    test_match();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
